// File: rtl/mem_db_tile_sched.sv
// Double-buffer tile scheduler for memory_core: fills the write bank, swaps banks, streams the previous tile out.
// Latency: in_data->data_in is combinational; ren_in at N pushes the skid FIFO at N+1, out_valid at N+2.
// Backpressure: in_ready drops at the tile quota; ren_in is credit-gated by FIFO occupancy plus the read in flight.
module mem_db_tile_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int SKID_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic [CNT_WIDTH-1:0]  cfg_depth,
  input  logic [CNT_WIDTH-1:0]  cfg_tiles,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  wen_in,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  ren_in,
  output logic                  switch_db,
  input  logic                  valid_out,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int FW = $clog2(SKID_DEPTH + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [FW:0]          OCC_LIM = (FW+1)'(SKID_DEPTH);
  localparam logic [PW-1:0]        PTR_LAST = PW'(SKID_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    SWAP   = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0]  depth, tiles, wcnt, rcnt, tiles_in;
  logic [CNT_WIDTH-1:0]  wcnt_nxt, rcnt_nxt;
  logic                  inflight;
  logic                  accept;
  logic                  wr_phase, rd_phase;
  logic                  credit_ok;
  logic [FW:0]           occ;

  logic [DATA_WIDTH-1:0] fifo_mem [SKID_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [FW-1:0]         fifo_cnt, fifo_cnt_nxt;
  logic                  push, pop;

  // Job accepted only from IDLE with a non-empty configuration.
  assign accept   = (state == IDLE) && start && clk_en && (cfg_depth != '0) && (cfg_tiles != '0);
  assign wr_phase = (state == FILL) || (state == STREAM);
  assign rd_phase = (state == STREAM) || (state == DRAIN);

  // Credit counts the word already requested from the core so the FIFO can never overflow.
  assign occ       = {1'b0, fifo_cnt} + {{FW{1'b0}}, inflight};
  assign credit_ok = occ < OCC_LIM;

  assign busy      = (state != IDLE);
  assign done      = clk_en && (state == DONE);
  assign switch_db = clk_en && (state == SWAP);
  assign in_ready  = clk_en && wr_phase && (wcnt < depth);
  assign wen_in    = in_valid && in_ready;
  assign data_in   = in_data;
  assign ren_in    = clk_en && rd_phase && (rcnt < depth) && credit_ok;

  assign out_valid = clk_en && (fifo_cnt != '0);
  assign out_data  = (fifo_cnt != '0) ? fifo_mem[rd_ptr] : '0;
  assign push      = clk_en && valid_out;
  assign pop       = out_valid && out_ready;

  assign wcnt_nxt     = wcnt + {{(CNT_WIDTH-1){1'b0}}, wen_in};
  assign rcnt_nxt     = rcnt + {{(CNT_WIDTH-1){1'b0}}, ren_in};
  assign fifo_cnt_nxt = fifo_cnt + {{(FW-1){1'b0}}, push} - {{(FW-1){1'b0}}, pop};

  // Next-state: tile boundaries are judged on the counts after this cycle's transfers.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = FILL;
      FILL:    if (wcnt_nxt == depth) state_nxt = SWAP;
      SWAP:    state_nxt = ((tiles_in + CNT_ONE) == tiles) ? DRAIN : STREAM;
      STREAM:  if ((wcnt_nxt == depth) && (rcnt_nxt == depth)) state_nxt = SWAP;
      DRAIN:   if ((rcnt == depth) && !inflight && !ren_in && (fifo_cnt_nxt == '0)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; frozen while clk_en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  // Job configuration, per-tile quotas and the in-flight read flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth    <= '0;
      tiles    <= '0;
      wcnt     <= '0;
      rcnt     <= '0;
      tiles_in <= '0;
      inflight <= 1'b0;
    end else if (clk_en) begin
      inflight <= ren_in;
      if (state == IDLE) begin
        if (accept) begin
          depth    <= cfg_depth;
          tiles    <= cfg_tiles;
          wcnt     <= '0;
          rcnt     <= '0;
          tiles_in <= '0;
        end
      end else if (state == SWAP) begin
        tiles_in <= tiles_in + CNT_ONE;
        wcnt     <= '0;
        rcnt     <= '0;
      end else begin
        wcnt <= wcnt_nxt;
        rcnt <= rcnt_nxt;
      end
    end
  end

  // Skid FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt_nxt;
    end
  end

  // Skid FIFO storage; contents are masked by the occupancy count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_out;
  end

endmodule
